cache_controller: RTL and testbench
===================================

Name: cache_controller

Overview:
- Initiator-side FSM that drives the 4-way set-associative cache array on behalf of a CPU port.
- Performs the lookup, fetches from main memory on a read miss, and fills the line.
- Writes through to main memory on every store.
- Owns the replacement decision: a per-set round-robin pointer drives the cache's replace_way input.

Parameters:
NUM_SETS, 32, sets in cache; index = addr[4+log2(NUM_SETS):5] (addr[9:5] at default)
NUM_WAYS, 4, ways per set; replace_way width = log2(NUM_WAYS)
TIMEOUT_CYCLES, 255, max cycles waiting for mem_ack before abort (8-bit counter)

Ports:
clk  in  1  clock; all state on rising edge
reset  in  1  asynchronous, active-high
cpu_req  in  1  request strobe; sampled only in IDLE
cpu_we  in  1  1=store, 0=load; sampled with cpu_req
cpu_addr  in  32  request address
cpu_wdata  in  32  store data
cpu_rdata  out  32  load data; valid while cpu_ready=1
cpu_ready  out  1  one-cycle completion pulse
cpu_err  out  1  asserted with cpu_ready on memory timeout
cpu_busy  out  1  high in every state except IDLE
cache_read  out  1  cache lookup enable
cache_write  out  1  cache write enable (one cycle)
cache_addr  out  32  latched request address
cache_wdata  out  32  store data or fetched fill data
cache_rdata  in  32  cache read data (combinational)
cache_hit  in  1  cache hit (combinational, valid with cache_read)
replace_way  out  2  way to allocate = rr_ptr[index]
mem_req  out  1  memory request; held until mem_ack
mem_we  out  1  memory write select
mem_addr  out  32  latched request address
mem_wdata  out  32  latched store data
mem_rdata  in  32  memory read data; valid with mem_ack
mem_ack  in  1  memory completion, one cycle

Behaviour:
- Reset (async, any state) -> IDLE.
  - All outputs 0.
  - rr_ptr[all sets] = 0; latched addr/data/we = 0; timeout counter = 0.
  - An in-flight mem_req is dropped; memory must tolerate the abandoned request.
- IDLE: if cpu_req=1, latch cpu_addr/cpu_we/cpu_wdata and go to LOOKUP. The CPU port is not sampled in any other state.
- LOOKUP (1 cycle): cache_read=1, cache_addr=latched addr; register hit_q=cache_hit.
  - Load hit: capture cache_rdata into cpu_rdata, go to RESP.
  - Load miss: go to MEM_RD.
  - Store: go to CWRITE.
- MEM_RD: mem_req=1, mem_we=0, counter increments each cycle.
  - mem_ack: capture mem_rdata, go to FILL.
  - Counter reaches TIMEOUT_CYCLES without ack: set err, go to RESP with no fill.
- FILL (1 cycle): cache_write=1, cache_wdata=fetched data, replace_way=rr_ptr[index]; rr_ptr[index] increments mod NUM_WAYS; cpu_rdata=fetched data; go to RESP.
- CWRITE (1 cycle): cache_write=1, cache_wdata=latched data, replace_way=rr_ptr[index].
  - rr_ptr[index] increments only if hit_q=0 (write-allocate).
  - Go to MEM_WR.
- MEM_WR: mem_req=1, mem_we=1, mem_wdata=latched data.
  - mem_ack: go to RESP.
  - Timeout: set err, go to RESP. The cache is already updated; no rollback.
- RESP (1 cycle): cpu_ready=1, cpu_err=err; then IDLE, clearing err and counter.
- Latency (cycles from the edge where cpu_req is sampled to cpu_ready high):
  - Load hit: 2.
  - Load miss: 3 + N, where N = cycles of mem_req before mem_ack (ack in first cycle, N=1 -> 4 total).
  - Store: 3 + N.
- mem_req, mem_addr and mem_we stay stable until the ack cycle. mem_req deasserts the cycle after mem_ack.
- mem_ack outside MEM_RD/MEM_WR is ignored.
- mem_ack in the same cycle the counter hits its limit: ack wins, no err.
- cache_read and cache_write are never asserted together.
- rr_ptr wraps 3->0. Pointers are independent per set.
- cpu_rdata holds its last value outside RESP. It is 0 after reset and unchanged on a timeout.

Test Plan:
- Reset, load 0x0000_0040 (set 2), memory returns 0xDEAD_BEEF after 3 cycles -> mem_req for 3 cycles; FILL with replace_way=0; cpu_ready at cycle 6, cpu_rdata=0xDEAD_BEEF; repeat the load -> hit, cpu_ready at cycle 2, no mem_req.
- Store 0x1234_5678 to 0x0000_0080 (miss) -> CWRITE with replace_way=0, rr_ptr[4] becomes 1; mem_req/mem_we=1 with mem_wdata=0x1234_5678; load same address -> hit returns 0x1234_5678.
- Five load misses to set 0 (addresses 0x000, 0x400, 0x800, 0xC00, 0x1000) -> replace_way sequence 0,1,2,3,0; store hit to a resident line leaves rr_ptr[0] unchanged.
- mem_ack withheld -> after 255 cycles cpu_ready=1 with cpu_err=1, no cache_write; next request completes normally with cpu_err=0. Second run: ack on the 255th cycle -> cpu_err=0.
- Assert reset during MEM_RD -> next cycle mem_req=0, cpu_busy=0, all outputs 0; a later access to set 2 uses replace_way=0.
- cpu_req held high through a miss -> a second access starts only after RESP returns to IDLE; spurious mem_ack in IDLE causes no state change.

Source files
------------

// File: rtl/cache_controller.sv
// cache_controller: CPU-side FSM for a set-associative write-through cache with per-set round-robin allocation.
module cache_controller #(
  parameter int NUM_SETS       = 32,
  parameter int NUM_WAYS       = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        cpu_req,
  input  logic                        cpu_we,
  input  logic [31:0]                 cpu_addr,
  input  logic [31:0]                 cpu_wdata,
  output logic [31:0]                 cpu_rdata,
  output logic                        cpu_ready,
  output logic                        cpu_err,
  output logic                        cpu_busy,
  output logic                        cache_read,
  output logic                        cache_write,
  output logic [31:0]                 cache_addr,
  output logic [31:0]                 cache_wdata,
  input  logic [31:0]                 cache_rdata,
  input  logic                        cache_hit,
  output logic [$clog2(NUM_WAYS)-1:0] replace_way,
  output logic                        mem_req,
  output logic                        mem_we,
  output logic [31:0]                 mem_addr,
  output logic [31:0]                 mem_wdata,
  input  logic [31:0]                 mem_rdata,
  input  logic                        mem_ack
);
  localparam int IW = $clog2(NUM_SETS);
  localparam int WW = $clog2(NUM_WAYS);
  localparam logic [WW-1:0] ONE = 1;
  localparam logic [7:0] LIMIT = 8'(TIMEOUT_CYCLES);
  typedef enum logic [2:0] {IDLE, LOOKUP, MEM_RD, FILL, CWRITE, MEM_WR, RESP} state_t;
  state_t state;
  logic we_q, hit_q;
  logic [31:0] addr_q, wdata_q;
  logic [7:0] cnt, cnt_nxt;
  logic [WW-1:0] rr_ptr [NUM_SETS];
  logic [IW-1:0] idx;
  assign idx = addr_q[4+IW:5];
  assign cnt_nxt = cnt + 8'd1;
  assign replace_way = rr_ptr[idx];
  assign cache_addr = addr_q;
  assign mem_addr = addr_q;
  assign mem_wdata = wdata_q;
  assign cpu_busy = state != IDLE;
  // Outputs are registered on entry to the state that owns them, so they line up with that state's cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      we_q        <= 1'b0;
      hit_q       <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cnt         <= '0;
      cpu_rdata   <= '0;
      cpu_ready   <= 1'b0;
      cpu_err     <= 1'b0;
      cache_read  <= 1'b0;
      cache_write <= 1'b0;
      cache_wdata <= '0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      for (int i = 0; i < NUM_SETS; i++) rr_ptr[i] <= '0;
    end else begin
      cpu_ready   <= 1'b0;
      cache_read  <= 1'b0;
      cache_write <= 1'b0;
      case (state)
        IDLE: if (cpu_req) begin
          addr_q     <= cpu_addr;
          we_q       <= cpu_we;
          wdata_q    <= cpu_wdata;
          cache_read <= 1'b1;
          state      <= LOOKUP;
        end
        LOOKUP: begin
          hit_q <= cache_hit;
          if (we_q) begin
            cache_wdata <= wdata_q;
            cache_write <= 1'b1;
            state       <= CWRITE;
          end else if (cache_hit) begin
            cpu_rdata <= cache_rdata;
            cpu_ready <= 1'b1;
            state     <= RESP;
          end else begin
            mem_req <= 1'b1;
            mem_we  <= 1'b0;
            state   <= MEM_RD;
          end
        end
        MEM_RD: begin
          cnt <= cnt_nxt;
          if (mem_ack) begin
            mem_req     <= 1'b0;
            cache_wdata <= mem_rdata;
            cache_write <= 1'b1;
            state       <= FILL;
          end else if (cnt_nxt == LIMIT) begin
            mem_req   <= 1'b0;
            cpu_err   <= 1'b1;
            cpu_ready <= 1'b1;
            state     <= RESP;
          end
        end
        FILL: begin
          rr_ptr[idx] <= rr_ptr[idx] + ONE;
          cpu_rdata   <= cache_wdata;
          cpu_ready   <= 1'b1;
          state       <= RESP;
        end
        CWRITE: begin
          if (!hit_q) rr_ptr[idx] <= rr_ptr[idx] + ONE;
          mem_req <= 1'b1;
          mem_we  <= 1'b1;
          state   <= MEM_WR;
        end
        MEM_WR: begin
          cnt <= cnt_nxt;
          if (mem_ack || cnt_nxt == LIMIT) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            cpu_err   <= !mem_ack;
            cpu_ready <= 1'b1;
            state     <= RESP;
          end
        end
        RESP: begin
          cpu_err <= 1'b0;
          cnt     <= '0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cache_controller.sv
// tb_cache_controller: directed vector bench with a behavioural cache array and a programmable-latency memory.
module tb_cache_controller;
  logic clk = 1'b0, reset = 1'b1;
  logic cpu_req = 1'b0, cpu_we = 1'b0;
  logic [31:0] cpu_addr = '0, cpu_wdata = '0;
  logic [31:0] cpu_rdata, cache_addr, cache_wdata, cache_rdata, mem_addr, mem_wdata, mem_rdata;
  logic cpu_ready, cpu_err, cpu_busy, cache_read, cache_write, cache_hit, mem_req, mem_we, mem_ack;
  logic [1:0] replace_way;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  cache_controller dut (
    .clk(clk), .reset(reset), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready), .cpu_err(cpu_err),
    .cpu_busy(cpu_busy), .cache_read(cache_read), .cache_write(cache_write), .cache_addr(cache_addr),
    .cache_wdata(cache_wdata), .cache_rdata(cache_rdata), .cache_hit(cache_hit),
    .replace_way(replace_way), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );
  // Cache array model: 32 sets x 4 ways, tag = addr[31:10]; not cleared by controller reset.
  bit cm_v [32][4];
  logic [21:0] cm_tag [32][4];
  logic [31:0] cm_data [32][4];
  logic [1:0] hway;
  always_comb begin
    cache_hit = 1'b0;
    cache_rdata = '0;
    hway = '0;
    for (int w = 0; w < 4; w++)
      if (cm_v[cache_addr[9:5]][w] && cm_tag[cache_addr[9:5]][w] == cache_addr[31:10]) begin
        cache_hit = 1'b1;
        cache_rdata = cm_data[cache_addr[9:5]][w];
        hway = 2'(w);
      end
  end
  always @(posedge clk) if (cache_write) begin
    cm_v[cache_addr[9:5]][cache_hit ? hway : replace_way] <= 1'b1;
    cm_tag[cache_addr[9:5]][cache_hit ? hway : replace_way] <= cache_addr[31:10];
    cm_data[cache_addr[9:5]][cache_hit ? hway : replace_way] <= cache_wdata;
  end
  // Memory: acks in the ack_after-th cycle of mem_req (0 = never); spur drives ack while idle.
  int ack_after = 0, req_cnt = 0;
  logic [31:0] mem_data_v = '0;
  bit spur = 1'b0;
  always @(negedge clk) begin
    if (mem_req) begin
      req_cnt = req_cnt + 1;
      mem_ack = (ack_after != 0 && req_cnt == ack_after);
      mem_rdata = mem_data_v;
    end else begin
      req_cnt = 0;
      mem_ack = spur;
      mem_rdata = 32'hBAD0_0000;
    end
  end
  int n_req = 0, n_wr = 0, n_rd = 0, overlap = 0;
  logic [1:0] last_way = '0;
  logic last_we = 1'b0;
  logic [31:0] last_wdata = '0;
  always @(negedge clk) begin
    if (mem_req) begin n_req++; last_we = mem_we; last_wdata = mem_wdata; end
    if (cache_write) begin n_wr++; last_way = replace_way; end
    if (cache_read) n_rd++;
    if (cache_read && cache_write) overlap++;
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask
  int b_req, b_wr, b_rd, lat;
  task automatic txn(input logic we, input logic [31:0] addr, wdata, input int ack, input logic [31:0] md);
    @(negedge clk);
    ack_after = ack; mem_data_v = md;
    b_req = n_req; b_wr = n_wr; b_rd = n_rd;
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
    @(negedge clk);
    cpu_req = 1'b0;
    lat = 1;
    while (!cpu_ready && lat < 600) begin @(negedge clk); lat++; end
  endtask
  typedef struct {
    logic we; logic [31:0] addr; logic [31:0] wdata; int ack; logic [31:0] md;
    logic [31:0] rdata; int lat; logic err; int nreq; int nwr; int way;
  } vec_t;
  vec_t v [16];
  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    //        we    addr           wdata          ack  md             rdata          lat  err  nreq nwr way
    v[0]  = '{1'b0, 32'h0000_0040, 32'h0,         3,   32'hDEAD_BEEF, 32'hDEAD_BEEF, 6,   1'b0, 3,   1,  0};
    v[1]  = '{1'b0, 32'h0000_0040, 32'h0,         1,   32'h0,         32'hDEAD_BEEF, 2,   1'b0, 0,   0,  0};
    v[2]  = '{1'b1, 32'h0000_0080, 32'h1234_5678, 1,   32'h0,         32'hDEAD_BEEF, 4,   1'b0, 1,   1,  0};
    v[3]  = '{1'b0, 32'h0000_0080, 32'h0,         1,   32'h0,         32'h1234_5678, 2,   1'b0, 0,   0,  0};
    v[4]  = '{1'b0, 32'h0000_0000, 32'h0,         1,   32'hA0,        32'hA0,        4,   1'b0, 1,   1,  0};
    v[5]  = '{1'b0, 32'h0000_0400, 32'h0,         1,   32'hA1,        32'hA1,        4,   1'b0, 1,   1,  1};
    v[6]  = '{1'b0, 32'h0000_0800, 32'h0,         1,   32'hA2,        32'hA2,        4,   1'b0, 1,   1,  2};
    v[7]  = '{1'b0, 32'h0000_0C00, 32'h0,         1,   32'hA3,        32'hA3,        4,   1'b0, 1,   1,  3};
    v[8]  = '{1'b0, 32'h0000_1000, 32'h0,         1,   32'hA4,        32'hA4,        4,   1'b0, 1,   1,  0};
    v[9]  = '{1'b1, 32'h0000_0400, 32'h55,        1,   32'h0,         32'hA4,        4,   1'b0, 1,   1,  1};
    v[10] = '{1'b0, 32'h0000_1400, 32'h0,         2,   32'hA5,        32'hA5,        5,   1'b0, 2,   1,  1};
    v[11] = '{1'b0, 32'h0000_0800, 32'h0,         1,   32'h0,         32'hA2,        2,   1'b0, 0,   0,  0};
    v[12] = '{1'b0, 32'h0000_2000, 32'h0,         0,   32'h0,         32'hA2,        257, 1'b1, 255, 0,  0};
    v[13] = '{1'b0, 32'h0000_2000, 32'h0,         1,   32'h77,        32'h77,        4,   1'b0, 1,   1,  2};
    v[14] = '{1'b0, 32'h0000_6000, 32'h0,         255, 32'h88,        32'h88,        258, 1'b0, 255, 1,  3};
    v[15] = '{1'b1, 32'h0000_20C0, 32'hCAFE_F00D, 4,   32'h0,         32'h88,        7,   1'b0, 4,   1,  0};
    repeat (2) @(negedge clk);
    chk("reset_outs", 32'(|{cpu_rdata, cpu_ready, cpu_err, cpu_busy, cache_read, cache_write, cache_addr,
        cache_wdata, replace_way, mem_req, mem_we, mem_addr, mem_wdata}), 32'h0);
    reset = 1'b0;
    for (int i = 0; i < 16; i++) begin
      txn(v[i].we, v[i].addr, v[i].wdata, v[i].ack, v[i].md);
      chk($sformatf("v%0d_lat", i), 32'(lat), 32'(v[i].lat));
      chk($sformatf("v%0d_rdata", i), cpu_rdata, v[i].rdata);
      chk($sformatf("v%0d_err", i), 32'(cpu_err), 32'(v[i].err));
      chk($sformatf("v%0d_nreq", i), 32'(n_req - b_req), 32'(v[i].nreq));
      chk($sformatf("v%0d_nwr", i), 32'(n_wr - b_wr), 32'(v[i].nwr));
      if (v[i].nwr > 0) chk($sformatf("v%0d_way", i), 32'(last_way), 32'(v[i].way));
      if (v[i].nreq > 0) chk($sformatf("v%0d_mem_we", i), 32'(last_we), 32'(v[i].we));
      if (v[i].we) chk($sformatf("v%0d_mem_wdata", i), last_wdata, v[i].wdata);
    end
    // Reset while waiting in MEM_RD for a set-2 miss.
    @(negedge clk);
    ack_after = 0; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_0440;
    @(negedge clk);
    cpu_req = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_reset_req", 32'(mem_req), 32'h1);
    reset = 1'b1;
    #1;
    chk("rst_mem_req", 32'(mem_req), 32'h0);
    chk("rst_busy", 32'(cpu_busy), 32'h0);
    chk("rst_rdata", cpu_rdata, 32'h0);
    chk("rst_outs", 32'(|{cpu_ready, cpu_err, cache_read, cache_write, cache_addr, cache_wdata,
        replace_way, mem_we, mem_addr, mem_wdata}), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    txn(1'b0, 32'h0000_0840, 32'h0, 1, 32'h99);
    chk("post_rst_lat", 32'(lat), 32'd4);
    chk("post_rst_way", 32'(last_way), 32'h0);
    chk("post_rst_rdata", cpu_rdata, 32'h99);
    // cpu_req held high across a miss: the next lookup waits for IDLE.
    @(negedge clk);
    ack_after = 2; mem_data_v = 32'h0C40_0C40; b_rd = n_rd;
    cpu_req = 1'b1; cpu_addr = 32'h0000_0C40;
    lat = 0;
    while (!cpu_ready && lat < 600) begin @(negedge clk); lat++; end
    chk("hold_lat", 32'(lat), 32'd5);
    chk("hold_way", 32'(last_way), 32'h1);
    chk("hold_lookups", 32'(n_rd - b_rd), 32'h1);
    @(negedge clk);
    chk("hold_idle_busy", 32'(cpu_busy), 32'h0);
    chk("hold_idle_read", 32'(cache_read), 32'h0);
    @(negedge clk);
    cpu_req = 1'b0;
    chk("hold_second_read", 32'(cache_read), 32'h1);
    @(negedge clk);
    chk("hold_second_ready", 32'(cpu_ready), 32'h1);
    chk("hold_second_rdata", cpu_rdata, 32'h0C40_0C40);
    // Spurious ack while idle.
    @(negedge clk);
    spur = 1'b1;
    repeat (3) @(negedge clk);
    chk("spur_quiet", 32'({cpu_busy, mem_req, cpu_ready, cache_read, cache_write}), 32'h0);
    spur = 1'b0;
    txn(1'b0, 32'h0000_0C40, 32'h0, 1, 32'h0);
    chk("spur_after_lat", 32'(lat), 32'd2);
    chk("rd_wr_overlap", 32'(overlap), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
